// File: rtl/cpu_pkg.sv
// Processor-wide types and sizes shared by the fetch unit, the core FSM and the RAM wrapper.
package cpu_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int SYS_ADDR_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE,
    ST_FAULT
  } fetch_state_t;

  // One tracked read in flight: capture strobe plus the byte lane it lands in.
  typedef struct packed {
    logic       en;
    logic [1:0] idx;
  } cap_t;

  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/ifetch_delay.sv
// Delay line that follows each issued RAM read so its byte is captured RD_LATENCY cycles later.
// Latency DEPTH cycles; no backpressure, flush drops every tracked read.
module ifetch_delay
  import cpu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  cap_t din,
  output cap_t dout
);

  cap_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/instr_fetch.sv
// Multicycle fetch of a little-endian 32-bit word from byte RAM; valid pulses 4+RD_LATENCY edges after start.
// No backpressure: start is taken only in IDLE; IFETCH_ALIGN_CHECK_EN adds the misaligned-pc fault pulse.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = SYS_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [31:0]       pc,
  input  logic [7:0]        mem_q,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       instr,
  output logic              valid,
  output logic              busy,
  output logic              fault
);

  fetch_state_t      state, state_nxt;
  logic [1:0]        issue_cnt, issue_nxt;
  logic [2:0]        cap_cnt, cap_nxt;
  logic [31:0]       asm_buf, buf_nxt, instr_nxt;
  logic              rden_nxt, valid_nxt, busy_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  cap_t              cap_in, cap_out;
  logic              unused_pc_hi;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q, fault_nxt;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign unused_pc_hi = ^(pc >> ADDR_W);

  // The read presented this cycle is byte issue_cnt-1; it is tagged now and captured later.
  assign cap_in.en  = mem_rden;
  assign cap_in.idx = issue_cnt - 2'd1;

  ifetch_delay #(.DEPTH(RD_LATENCY)) u_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .din   (cap_in),
    .dout  (cap_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_nxt = issue_cnt;
    cap_nxt   = cap_cnt;
    buf_nxt   = asm_buf;
    instr_nxt = instr;
    rden_nxt  = 1'b0;
    addr_nxt  = mem_addr;
    valid_nxt = 1'b0;
    busy_nxt  = busy;
`ifdef IFETCH_ALIGN_CHECK_EN
    fault_nxt = 1'b0;
`endif

    if (cap_out.en) begin
      buf_nxt = put_byte(asm_buf, cap_out.idx, mem_q);
      cap_nxt = cap_cnt + 3'd1;
    end

    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          busy_nxt = 1'b1;
          cap_nxt  = 3'd0;
`ifdef IFETCH_ALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            state_nxt = ST_FAULT;
          end else
`endif
          begin
            state_nxt = ST_ISSUE;
            rden_nxt  = 1'b1;
            addr_nxt  = pc[ADDR_W-1:0];
            issue_nxt = 2'd1;
          end
        end
      end
      ST_ISSUE: begin
        // issue_cnt wraps to 0 once byte 3 has been presented
        if (issue_cnt == 2'd0) begin
          state_nxt = ST_DRAIN;
        end else begin
          rden_nxt  = 1'b1;
          addr_nxt  = mem_addr + ADDR_W'(1);
          issue_nxt = issue_cnt + 2'd1;
        end
      end
      ST_DRAIN: begin
        if (cap_nxt == 3'(INSTR_BYTES)) begin
          state_nxt = ST_DONE;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          instr_nxt = buf_nxt;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      ST_FAULT: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        fault_nxt = 1'b1;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (flush && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      rden_nxt  = 1'b0;
      busy_nxt  = 1'b0;
      valid_nxt = 1'b0;
      instr_nxt = instr;
      cap_nxt   = 3'd0;
      issue_nxt = 2'd0;
`ifdef IFETCH_ALIGN_CHECK_EN
      fault_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= 2'd0;
      cap_cnt   <= 3'd0;
      asm_buf   <= 32'd0;
      instr     <= 32'd0;
      mem_rden  <= 1'b0;
      mem_addr  <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      issue_cnt <= issue_nxt;
      cap_cnt   <= cap_nxt;
      asm_buf   <= buf_nxt;
      instr     <= instr_nxt;
      mem_rden  <= rden_nxt;
      mem_addr  <= addr_nxt;
      valid     <= valid_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_nxt;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte RAM model, expected words queued at start and popped on valid.
module tb_instr_fetch;

  localparam int LAT = 1;
  localparam int AW  = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   pc    = 32'd0;
  logic [7:0]    mem_q;
  logic          mem_rden;
  logic [AW-1:0] mem_addr;
  logic [31:0]   instr;
  logic          valid, busy, fault;

  int errors = 0;
  int checks = 0;

  logic [7:0]    ram    [0:65535];
  logic [7:0]    q_pipe [LAT];
  logic [31:0]   exp_q    [$];
  logic [AW-1:0] addr_log [$];
  int            valid_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RD_LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .pc       (pc),
    .mem_q    (mem_q),
    .mem_rden (mem_rden),
    .mem_addr (mem_addr),
    .instr    (instr),
    .valid    (valid),
    .busy     (busy),
    .fault    (fault)
  );

  // Synchronous RAM: address taken on the edge after it is presented, data LAT edges later.
  always @(posedge clk) begin
    if (mem_rden) q_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[LAT-1];

  always @(negedge clk) begin
    if (mem_rden) addr_log.push_back(mem_addr);
    if (valid) valid_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle before the sampling edge E0; returns one cycle after E_{5+LAT}.
  task automatic run_fetch(input string tag, input logic [31:0] p,
                           input logic [31:0] exp, input int repulse);
    int  lat;
    bit  seen;
    int  abase;
    int  vbase;
    logic [AW-1:0] ea;
    abase = addr_log.size();
    vbase = valid_cnt;
    exp_q.push_back(exp);
    start = 1'b1;
    pc    = p;
    tick();
    start = 1'b0;
    check({tag, "_busy_hi"}, 32'(busy), 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      start = (c == repulse);
      if (valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    start = 1'b0;
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(lat), 32'(4 + LAT));
      check({tag, "_instr"}, instr, exp_q.pop_front());
      check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    end else begin
      void'(exp_q.pop_front());
    end
    tick();
    check({tag, "_valid_1cyc"}, 32'(valid), 32'd0);
    check({tag, "_nvalid"}, 32'(valid_cnt - vbase), 32'd1);
    check({tag, "_nreads"}, 32'(addr_log.size() - abase), 32'd4);
    for (int k = 0; k < 4; k++) begin
      ea = p[AW-1:0] + AW'(k);
      if (abase + k < addr_log.size())
        check({tag, "_addr"}, 32'(addr_log[abase + k]), 32'(ea));
    end
  endtask

  initial begin
    int abase;
    int vbase;

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0010] = 8'h93; ram[16'h0011] = 8'h00; ram[16'h0012] = 8'h50; ram[16'h0013] = 8'h00;
    ram[16'hFFFE] = 8'hEF; ram[16'hFFFF] = 8'hBE; ram[16'h0000] = 8'hAD; ram[16'h0001] = 8'hDE;
    ram[16'h0002] = 8'h37; ram[16'h0003] = 8'h13;
    ram[16'h0020] = 8'h44; ram[16'h0021] = 8'h33; ram[16'h0022] = 8'h22; ram[16'h0023] = 8'h11;
    ram[16'h0014] = 8'hA1; ram[16'h0015] = 8'hB2; ram[16'h0016] = 8'hC3;

    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_rden",  32'(mem_rden), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst = 1'b1;
    tick();

    run_fetch("basic", 32'h0000_0010, 32'h0050_0093, 0);
    run_fetch("wrap",  32'h1234_FFFE, 32'hDEAD_BEEF, 0);

    // start and flush together in IDLE: request dropped
    abase = addr_log.size();
    vbase = valid_cnt;
    start = 1'b1;
    flush = 1'b1;
    pc    = 32'h10;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("sf_busy", 32'(busy), 32'd0);
    repeat (8) tick();
    check("sf_reads", 32'(addr_log.size() - abase), 32'd0);
    check("sf_valid", 32'(valid_cnt - vbase), 32'd0);

    // flush two cycles after start
    abase = addr_log.size();
    vbase = valid_cnt;
    start = 1'b1;
    pc    = 32'h10;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy",  32'(busy), 32'd0);
    check("fl_rden",  32'(mem_rden), 32'd0);
    check("fl_instr", instr, 32'hDEAD_BEEF);
    repeat (8) tick();
    check("fl_valid", 32'(valid_cnt - vbase), 32'd0);
    check("fl_reads", 32'(addr_log.size() - abase), 32'd2);
    check("fl_instr_hold", instr, 32'hDEAD_BEEF);
    run_fetch("after_flush", 32'h20, 32'h1122_3344, 0);

    run_fetch("repulse", 32'h10, 32'h0050_0093, 2);
    repeat (8) tick();
    check("repulse_idle", 32'(busy), 32'd0);

    // asynchronous reset mid-fetch
    start = 1'b1;
    pc    = 32'h10;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("mrst_rden",  32'(mem_rden), 32'd0);
    check("mrst_addr",  32'(mem_addr), 32'd0);
    check("mrst_instr", instr, 32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_busy",  32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    run_fetch("post_rst", 32'h0, 32'h1337_DEAD, 0);

`ifdef IFETCH_ALIGN_CHECK_EN
    abase = addr_log.size();
    vbase = valid_cnt;
    start = 1'b1;
    pc    = 32'h13;
    tick();
    start = 1'b0;
    check("mis_busy",  32'(busy), 32'd1);
    check("mis_rden",  32'(mem_rden), 32'd0);
    tick();
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_busy_lo", 32'(busy), 32'd0);
    tick();
    check("mis_fault_1cyc", 32'(fault), 32'd0);
    repeat (6) tick();
    check("mis_reads", 32'(addr_log.size() - abase), 32'd0);
    check("mis_valid", 32'(valid_cnt - vbase), 32'd0);
    check("mis_instr", instr, 32'h1337_DEAD);
`else
    run_fetch("unaligned", 32'h13, 32'hC3B2_A100, 0);
    check("no_fault", 32'(fault), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
